// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues SRAM loads/stores and hands results to writeback in order.
// Optional MEM_STAGE_STALL_CNT_EN adds perf_stall_cnt (saturating count of stalled offers).
module mem_access_stage #(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10,
    parameter int R_SIZE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [A_SIZE-1:0] ex_addr,
    input  logic [D_SIZE-1:0] ex_wdata,
    input  logic [D_SIZE-1:0] ex_result,
    input  logic [R_SIZE-1:0] ex_dst,
    input  logic              ex_we,
    output logic              mem_read,
    output logic              mem_write,
    output logic [A_SIZE-1:0] mem_address,
    output logic [D_SIZE-1:0] mem_data_in,
    input  logic [D_SIZE-1:0] mem_data_out,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [D_SIZE-1:0] wb_data,
    output logic [R_SIZE-1:0] wb_dst,
    output logic              wb_we
`ifdef MEM_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef enum logic {S_RUN, S_LOAD} state_t;

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              is_load;
    logic              is_store;
    logic [R_SIZE-1:0] ld_dst;

    // Store wins when both load and store are flagged, so no read is issued.
    assign is_store = ex_store;
    assign is_load  = ex_load & ~ex_store;

    // State register; reset abandons any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake, SRAM strobes and next state; strobes only fire on an accept.
    always_comb begin
        state_nx    = state;
        ex_ready    = 1'b0;
        accept      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        unique case (state)
            S_RUN: begin
                ex_ready = rst_n & (~wb_valid | wb_ready);
                accept   = ex_valid & ex_ready;
                if (accept && is_store) begin
                    mem_write   = 1'b1;
                    mem_address = ex_addr;
                    mem_data_in = ex_wdata;
                end else if (accept && is_load) begin
                    mem_read    = 1'b1;
                    mem_address = ex_addr;
                    state_nx    = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = S_RUN;
            end
            default: begin
                state_nx = S_RUN;
            end
        endcase
    end

    // Remember the load's destination while the SRAM read is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_dst <= '0;
        end else if (accept && is_load) begin
            ld_dst <= ex_dst;
        end
    end

    // Writeback slot: filled by load capture or by an accepted ALU/store op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_dst   <= '0;
            wb_we    <= 1'b0;
        end else if (state == S_LOAD) begin
            wb_valid <= 1'b1;
            wb_data  <= mem_data_out;
            wb_dst   <= ld_dst;
            wb_we    <= 1'b1;
        end else if (accept && !is_load) begin
            wb_valid <= 1'b1;
            wb_data  <= is_store ? '0 : ex_result;
            wb_dst   <= ex_dst;
            wb_we    <= is_store ? 1'b0 : ex_we;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

`ifdef MEM_STAGE_STALL_CNT_EN
    // Count cycles where execute offers an op that cannot be taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if (ex_valid && !ex_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: queue-based model checked every cycle
// plus directed vectors with literal expectations.
module tb_mem_access_stage;
    localparam int D = 32;
    localparam int A = 10;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ex_valid = 1'b0;
    logic         ex_ready;
    logic         ex_load = 1'b0;
    logic         ex_store = 1'b0;
    logic [A-1:0] ex_addr = '0;
    logic [D-1:0] ex_wdata = '0;
    logic [D-1:0] ex_result = '0;
    logic [R-1:0] ex_dst = '0;
    logic         ex_we = 1'b0;
    logic         mem_read;
    logic         mem_write;
    logic [A-1:0] mem_address;
    logic [D-1:0] mem_data_in;
    logic [D-1:0] mem_data_out = '0;
    logic         wb_valid;
    logic         wb_ready = 1'b1;
    logic [D-1:0] wb_data;
    logic [R-1:0] wb_dst;
    logic         wb_we;
`ifdef MEM_STAGE_STALL_CNT_EN
    logic [31:0]  perf_stall_cnt;
    logic [31:0]  cnt0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.D_SIZE(D), .A_SIZE(A), .R_SIZE(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_load(ex_load), .ex_store(ex_store),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_result(ex_result), .ex_dst(ex_dst), .ex_we(ex_we),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_dst(wb_dst), .wb_we(wb_we)
`ifdef MEM_STAGE_STALL_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // SRAM fixture: registered read, zero when not read
    logic [D-1:0] sram [0:(1<<A)-1];
    logic [D-1:0] ref_mem [0:(1<<A)-1];
    initial begin
        for (int i = 0; i < (1 << A); i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
    end
    always @(posedge clk) begin
        if (mem_write) sram[mem_address] <= mem_data_in;
        mem_data_out <= mem_read ? sram[mem_address] : '0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-order queue of results, each visible from a given cycle
    typedef struct {
        logic [D-1:0] data;
        logic [R-1:0] dst;
        logic         we;
        int           vis;
    } ent_t;
    ent_t        q[$];
    int          cyc = 0;
    logic        m_valid = 0, m_ready = 0, m_acc = 0, m_rd = 0, m_wr = 0;
    logic [31:0] m_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            m_valid = 0; m_ready = 0; m_acc = 0; m_rd = 0; m_wr = 0;
            chk("rst ex_ready", ex_ready, 0);
            chk("rst mem_read", mem_read, 0);
            chk("rst mem_write", mem_write, 0);
            chk("rst mem_address", mem_address, 0);
            chk("rst mem_data_in", mem_data_in, 0);
            chk("rst wb_valid", wb_valid, 0);
            chk("rst wb_data", wb_data, 0);
            chk("rst wb_dst", wb_dst, 0);
            chk("rst wb_we", wb_we, 0);
        end else begin
            m_valid = q.size() > 0 && q[0].vis <= cyc;
            m_ready = q.size() == 0 || (m_valid && wb_ready);
            m_acc = ex_valid && m_ready;
            m_rd = m_acc && ex_load && !ex_store;
            m_wr = m_acc && ex_store;
            chk("m ex_ready", ex_ready, m_ready);
            chk("m mem_read", mem_read, m_rd);
            chk("m mem_write", mem_write, m_wr);
            chk("m mem_address", mem_address, (m_rd || m_wr) ? ex_addr : '0);
            chk("m mem_data_in", mem_data_in, m_wr ? ex_wdata : '0);
            chk("m wb_valid", wb_valid, m_valid);
            if (m_valid) begin
                chk("m wb_data", wb_data, q[0].data);
                chk("m wb_we", wb_we, q[0].we);
                if (q[0].we) chk("m wb_dst", wb_dst, q[0].dst);
            end
        end
`ifdef MEM_STAGE_STALL_CNT_EN
        chk("m perf_stall_cnt", perf_stall_cnt, m_cnt);
`endif
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (ex_valid && !m_ready && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_valid && wb_ready) void'(q.pop_front());
            if (m_acc) begin
                if (ex_store) begin
                    ref_mem[ex_addr] = ex_wdata;
                    q.push_back('{'0, ex_dst, 1'b0, cyc + 1});
                end else if (ex_load) begin
                    q.push_back('{ref_mem[ex_addr], ex_dst, 1'b1, cyc + 2});
                end else begin
                    q.push_back('{ex_result, ex_dst, ex_we, cyc + 1});
                end
            end
            cyc++;
        end
    end

    task automatic drv(input logic v, input logic ld, input logic st,
                       input logic [A-1:0] a, input logic [D-1:0] wd,
                       input logic [D-1:0] res, input logic [R-1:0] d,
                       input logic we, input logic wbr);
        ex_valid = v; ex_load = ld; ex_store = st; ex_addr = a;
        ex_wdata = wd; ex_result = res; ex_dst = d; ex_we = we;
        wb_ready = wbr;
    endtask

    task automatic idle(input logic wbr);
        drv(0, 0, 0, '0, '0, '0, '0, 0, wbr);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle(1);
        mid;
        chk("reset wb_valid", wb_valid, 0);
        chk("reset ex_ready", ex_ready, 0);
        tick; tick;
        rst_n = 1'b1;

        // ALU op
        drv(1, 0, 0, '0, '0, 32'h1234, 3'd3, 1, 1);
        mid; chk("t1 ex_ready", ex_ready, 1);
        tick; idle(1);
        mid;
        chk("t1 wb_valid", wb_valid, 1);
        chk("t1 wb_data", wb_data, 32'h1234);
        chk("t1 wb_dst", wb_dst, 3);
        chk("t1 wb_we", wb_we, 1);
        tick;

        // store then load same address
        drv(1, 0, 1, 10'd5, 32'hDEAD, '0, 3'd0, 1, 1);
        mid;
        chk("t2 mem_write", mem_write, 1);
        chk("t2 mem_address", mem_address, 5);
        chk("t2 mem_data_in", mem_data_in, 32'hDEAD);
        tick;
        drv(1, 1, 0, 10'd5, '0, '0, 3'd2, 1, 1);
        mid;
        chk("t2 write pulse", mem_write, 0);
        chk("t2 mem_read", mem_read, 1);
        chk("t2 store wb_we", wb_we, 0);
        chk("t2 store wb_data", wb_data, 0);
        tick; idle(1);
        mid; chk("t2 slot empty", wb_valid, 0);
        tick;
        mid;
        chk("t2 ld wb_valid", wb_valid, 1);
        chk("t2 ld wb_data", wb_data, 32'hDEAD);
        chk("t2 ld wb_we", wb_we, 1);
        chk("t2 ld wb_dst", wb_dst, 2);
        tick;

        // load+store both set behaves as store
        drv(1, 1, 1, 10'd7, 32'h77, '0, 3'd0, 1, 1);
        mid;
        chk("both mem_read", mem_read, 0);
        chk("both mem_write", mem_write, 1);
        tick;
        drv(1, 0, 1, 10'd1, 32'h1111, '0, 3'd0, 0, 1); tick;
        drv(1, 0, 1, 10'd2, 32'h2222, '0, 3'd0, 0, 1); tick;

        // back-to-back loads, then a held ALU op
`ifdef MEM_STAGE_STALL_CNT_EN
        cnt0 = perf_stall_cnt;
`endif
        drv(1, 1, 0, 10'd1, '0, '0, 3'd4, 1, 1);
        mid; chk("t3 c0 mem_read", mem_read, 1);
        tick; drv(1, 1, 0, 10'd2, '0, '0, 3'd5, 1, 1);
        mid;
        chk("t3 c1 ex_ready", ex_ready, 0);
        chk("t3 c1 mem_read", mem_read, 0);
        tick;
        mid;
        chk("t3 c2 ex_ready", ex_ready, 1);
        chk("t3 c2 mem_read", mem_read, 1);
        chk("t3 c2 wb_data", wb_data, 32'h1111);
        chk("t3 c2 wb_dst", wb_dst, 4);
        tick; drv(1, 0, 0, '0, '0, 32'h33, 3'd6, 1, 1);
        mid;
        chk("t3 c3 ex_ready", ex_ready, 0);
        chk("t3 c3 mem_read", mem_read, 0);
        chk("t3 c3 wb_valid", wb_valid, 0);
        tick;
        mid;
        chk("t3 c4 ex_ready", ex_ready, 1);
        chk("t3 c4 wb_data", wb_data, 32'h2222);
        chk("t3 c4 wb_dst", wb_dst, 5);
        tick;

        // writeback backpressure
        drv(1, 0, 0, '0, '0, 32'h44, 3'd7, 0, 1);
        mid; chk("t4 alu wb_data", wb_data, 32'h33);
        tick; idle(0);
        mid;
        chk("t4 a1 ex_ready", ex_ready, 0);
        chk("t4 a1 wb_data", wb_data, 32'h44);
        chk("t4 a1 wb_we", wb_we, 0);
        tick;
        for (int i = 0; i < 2; i++) begin
            drv(1, 0, 0, '0, '0, 32'h55, 3'd1, 1, 0);
            mid;
            chk("t4 stall ex_ready", ex_ready, 0);
            chk("t4 stall wb_data", wb_data, 32'h44);
            chk("t4 stall wb_valid", wb_valid, 1);
            tick;
        end
        drv(1, 0, 0, '0, '0, 32'h55, 3'd1, 1, 1);
        mid;
        chk("t4 rel ex_ready", ex_ready, 1);
        chk("t4 rel wb_data", wb_data, 32'h44);
        tick; idle(1);
        mid;
        chk("t4 drain wb_data", wb_data, 32'h55);
        chk("t4 drain wb_dst", wb_dst, 1);
`ifdef MEM_STAGE_STALL_CNT_EN
        chk("t6 stall delta", perf_stall_cnt - cnt0, 4);
`endif
        tick;

        // reset in the middle of a load
        drv(1, 1, 0, 10'd7, '0, '0, 3'd3, 1, 1);
        tick; idle(1);
        rst_n = 1'b0;
        mid;
        chk("t5 rst wb_valid", wb_valid, 0);
        chk("t5 rst ex_ready", ex_ready, 0);
        tick;
        rst_n = 1'b1;
        mid;
        chk("t5 post wb_valid", wb_valid, 0);
        chk("t5 post ex_ready", ex_ready, 1);
        tick;
        mid; chk("t5 no entry", wb_valid, 0);
        tick;

        // load of the address written while both flags were set
        drv(1, 1, 0, 10'd7, '0, '0, 3'd6, 1, 1);
        tick; idle(1);
        tick;
        mid;
        chk("both ld wb_data", wb_data, 32'h77);
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
